// File: rtl/lampfpu_log_arbiter.sv
// Round-robin arbiter that shares one lampFPU_log unit among NUM_REQ requesters.
// Only one operation is in flight at a time. A watchdog aborts the operation if
// log_valid_i does not arrive within TIMEOUT_CYC cycles of the start strobe.
//
// state | meaning
// IDLE  | no operation in flight; grant the next requester round-robin
// ISSUE | one-cycle doLog strobe to the log unit; timeout counter runs from 0
// WAIT  | wait for log_valid_i or the timeout count
// RESP  | hold the response until resp_ready_i is seen
module lampfpu_log_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  input  logic [NUM_REQ*20-1:0] req_op_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  output logic                  log_doLog_o,
  output logic [19:0]           log_op_o,
  input  logic                  log_valid_i,
  input  logic [15:0]           log_res_i,
  input  logic [2:0]            log_flags_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [2:0]            resp_id_o,
  output logic [15:0]           resp_res_o,
  output logic [2:0]            resp_flags_o,
  output logic                  resp_timeout_o
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      rr_q, rr_d;
  logic [2:0]      id_q, id_d;
  logic [19:0]     op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     res_q, res_d;
  logic [2:0]      flags_q, flags_d;
  logic            tmo_q, tmo_d;

  logic [7:0]          valid_pad;
  logic                gnt_found;
  logic [2:0]          gnt_idx;
  logic [19:0]         gnt_op;
  logic [NUM_REQ-1:0]  gnt_vec;
  logic [NUM_REQ-1:0]  ready_vec;

  // Unused upper lanes are zero, so indices >= NUM_REQ can never be granted.
  assign valid_pad = 8'(req_valid_i);

  always_comb begin
    logic [3:0] sum;
    gnt_found = 1'b0;
    gnt_idx   = 3'd0;
    sum       = 4'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_q} + 4'(i);
      if (sum >= 4'(NUM_REQ)) begin
        sum = sum - 4'(NUM_REQ);
      end
      if (!gnt_found && valid_pad[sum[2:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = sum[2:0];
      end
    end
  end

  always_comb begin
    gnt_op  = 20'd0;
    gnt_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == 3'(i)) begin
        gnt_op     = req_op_i[i*20 +: 20];
        gnt_vec[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    id_d      = id_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    flags_d   = flags_q;
    tmo_d     = tmo_q;
    ready_vec = '0;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          ready_vec = gnt_vec;
          id_d      = gnt_idx;
          op_d      = gnt_op;
          cnt_d     = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        // Counting already in ISSUE puts the abort exactly TIMEOUT_CYC cycles after doLog.
        cnt_d   = cnt_q + CW'(1);
        state_d = WAIT;
      end
      WAIT: begin
        if (log_valid_i) begin
          res_d   = log_res_i;
          flags_d = log_flags_i;
          tmo_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q >= CW'(TIMEOUT_CYC - 1)) begin
          res_d   = 16'd0;
          flags_d = 3'd0;
          tmo_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          rr_d    = (id_q == 3'(NUM_REQ - 1)) ? 3'd0 : id_q + 3'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= 3'd0;
      id_q    <= 3'd0;
      op_q    <= 20'd0;
      cnt_q   <= '0;
      res_q   <= 16'd0;
      flags_q <= 3'd0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      tmo_q   <= tmo_d;
    end
  end

  // The grant is combinational in IDLE; masking with rst keeps it low during reset.
  assign req_ready_o    = ready_vec & {NUM_REQ{~rst}};
  assign log_doLog_o    = (state_q == ISSUE);
  assign log_op_o       = (state_q != IDLE) ? op_q : 20'd0;
  assign resp_valid_o   = (state_q == RESP);
  assign resp_id_o      = id_q;
  assign resp_res_o     = res_q;
  assign resp_flags_o   = flags_q;
  assign resp_timeout_o = tmo_q;

endmodule
